pid_cntrl: RTL

- Consumes the saturated 10-bit signed pitch error from the saturate stage.
- Computes a registered 16-bit signed PID control word for the Segway balance loop.
- Keeps an integrator and an error-history queue for the D term. The D difference is saturated internally to 7 bits.
- Output feeds the downstream steering/motor-drive mixing stage, qualified by a one-cycle valid pulse.

---
 rtl/pid_cntrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/pid_cntrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pid_cntrl                                                     |
// | Purpose  : Two-stage PID balance controller, 10-bit error -> 16-bit word |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pid_cntrl #(
   parameter int P_COEFF = 14,
   parameter int D_COEFF = 6,
   parameter int Q_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               err_vld,
   input  logic signed [9:0]  err_sat,
   input  logic               moving,
   output logic signed [15:0] PID_cntrl,
   output logic               PID_vld
);

   localparam logic signed [5:0]  c_p_coeff = 6'(P_COEFF);
   localparam logic signed [6:0]  c_d_coeff = 7'(D_COEFF);
   localparam logic signed [15:0] c_p_ext   = 16'(c_p_coeff);
   localparam logic signed [15:0] c_d_ext   = 16'(c_d_coeff);
   localparam logic signed [6:0]  c_d_max   = 7'sd63;
   localparam logic signed [6:0]  c_d_min   = -7'sd64;

   logic signed [9:0]  r_queue [Q_DEPTH];
   logic signed [17:0] r_integ;
   logic signed [15:0] r_p_reg;
   logic signed [15:0] r_d_reg;
   logic               r_s1_vld;

   logic signed [15:0] w_err_ext16;
   logic signed [17:0] w_err_ext18;
   logic signed [17:0] w_sum;
   logic               w_ovf;
   logic signed [10:0] w_d_diff;
   logic signed [6:0]  w_d_sat;
   logic signed [15:0] w_d_sat_ext;
   logic signed [15:0] w_i_term;

   assign w_err_ext16 = {{6{err_sat[9]}}, err_sat};
   assign w_err_ext18 = {{8{err_sat[9]}}, err_sat};
   assign w_sum       = r_integ + w_err_ext18;
   // Signed overflow: both operands agree in sign but the sum does not.
   assign w_ovf       = (r_integ[17] == w_err_ext18[17]) && (w_sum[17] != r_integ[17]);
   assign w_d_diff    = {err_sat[9], err_sat} - {r_queue[Q_DEPTH-1][9], r_queue[Q_DEPTH-1]};
   assign w_d_sat_ext = 16'(w_d_sat);
   assign w_i_term    = {{4{r_integ[17]}}, r_integ[17:6]};

   always_comb begin
      w_d_sat = w_d_diff[6:0];
      if (!w_d_diff[10] && (w_d_diff[9:6] != 4'h0))
         w_d_sat = c_d_max;
      else if (w_d_diff[10] && (w_d_diff[9:6] != 4'hF))
         w_d_sat = c_d_min;
   end

   // Error history: index 0 is newest, Q_DEPTH-1 is the oldest sample.
   generate
      for (genvar gi = 0; gi < Q_DEPTH; gi++) begin : g_queue
         if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  r_queue[0] <= '0;
               else if (err_vld)
                  r_queue[0] <= err_sat;
            end
         end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  r_queue[gi] <= '0;
               else if (err_vld)
                  r_queue[gi] <= r_queue[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_integ <= '0;
      else if (!moving)
         r_integ <= '0;
      else if (err_vld && !w_ovf)
         r_integ <= w_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_reg  <= '0;
         r_d_reg  <= '0;
         r_s1_vld <= 1'b0;
      end else begin
         r_s1_vld <= err_vld;
         if (err_vld) begin
            r_p_reg <= w_err_ext16 * c_p_ext;
            r_d_reg <= w_d_sat_ext * c_d_ext;
         end
      end
   end

   // Sum range with legal coefficients fits in 16 bits, so no clamp here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PID_cntrl <= '0;
         PID_vld   <= 1'b0;
      end else begin
         PID_vld <= r_s1_vld;
         if (r_s1_vld)
            PID_cntrl <= r_p_reg + w_i_term + r_d_reg;
      end
   end

endmodule
`default_nettype wire
